branch_select_unit: RTL and testbench
=====================================

# branch_select_unit

Parametrised, registered branch-resolution unit for the KGP-RISC execute stage. It latches ALU condition flags and evaluates an 8-way branch op against them. It produces a registered next-PC select with a misprediction flag, and keeps a DEPTH-entry table of 2-bit saturating counters that the fetch stage reads for taken/not-taken prediction. It replaces the purely combinational carry/flag branch selector in the PC-update path.

## Interface
- PC_W, 32, width of PC and branch PC inputs.
- DEPTH, 16, prediction-table entries; power of two, 2..256.
- IDX_W, $clog2(DEPTH), derived, not overridden.

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  freezes all state and outputs while high.
- flag_we  in  1  latch the four flag inputs this cycle.
- carry_in, zero_in, sign_in, ovf_in  in  1 each  ALU flags.
- br_valid  in  1  branch op presented this cycle.
- br_op  in  3  000 seq, 001 jump-imm, 010 jump-reg, 011 br-carry, 100 br-zero, 101 br-sign, 110 br-ovf, 111 br-not-zero.
- br_pc  in  PC_W  PC of the resolving branch; table index = br_pc[IDX_W+1:2].
- br_pred  in  1  prediction fetch used for this branch.
- lk_pc  in  PC_W  fetch lookup PC; index = lk_pc[IDX_W+1:2].
- lk_taken  out  1  combinational: MSB of the addressed counter.
- res_valid  out  1  registered: resolution result valid.
- pc_sel  out  2  registered: 00 PC+4, 01 immediate target, 10 register target.
- taken  out  1  registered: branch resolved taken.
- mispredict  out  1  registered: conditional branch where the resolved outcome differs from br_pred.

## Operation
- Flag register: 4 bits {C,Z,S,V}. Loads on flag_we & ~stall. A branch in the same cycle as flag_we evaluates the pre-update flags. A flag write lands before the next cycle's branch.
- Condition evaluation (br_valid & ~stall):
  - 000 → taken=0, pc_sel=00.
  - 001 → taken=1, pc_sel=01.
  - 010 → taken=1, pc_sel=10.
  - 011/100/101/110 → taken=C/Z/S/V respectively. pc_sel=01 if taken, else 00.
  - 111 → taken=~Z, same pc_sel rule.
- mispredict=1 only for ops 011–111 when taken≠br_pred. Ops 000–010 always give mispredict=0, and br_pred is ignored for them.
- Prediction table: DEPTH × 2-bit counters.
  - Updated only by conditional ops (011–111) that are resolved. Increment on taken, saturating at 11. Decrement on not-taken, saturating at 00.
  - Ops 000–010 never touch the table.
- Lookup and update to the same index in one cycle: lk_taken returns the pre-update value.
- br_valid=0 & ~stall → next cycle res_valid=0, pc_sel=00, taken=0, mispredict=0.
- stall=1: flags, table and all registered outputs hold. lk_taken still reflects the current table.
- Reset (synchronous, takes priority over stall): flags=0, every counter=01 (weakly not-taken), res_valid=0, pc_sel=00, taken=0, mispredict=0. Reset clears an in-flight resolution; no result is produced for a branch presented in the reset cycle.

## Timing
- Resolution latency: 1 cycle. Inputs are sampled at edge N; res_valid/pc_sel/taken/mispredict are valid after edge N and held for exactly one cycle unless stalled.
- Back-to-back branches are accepted every cycle, throughput 1.
- Table update commits at the same edge as the result register. A lookup in cycle N+1 sees the new value.
- lk_taken: combinational from lk_pc and table state; no added latency.
- Index wrap: PCs differing only above bit IDX_W+1 alias to the same counter; this is intended.

## Test plan
- Reset, then lk_pc=0x0,0x4,…,0x3C → lk_taken=0 for all 16 entries; all registered outputs 0.
- flag_we with C=1, then br_op=011, br_pred=0, br_pc=0x40 → next cycle res_valid=1, pc_sel=01, taken=1, mispredict=1. A lookup at lk_pc=0x40 then shows the counter at 10, lk_taken=1.
- Same cycle: flag_we with Z=1 (old Z=0) and br_op=100, br_pred=0 → taken=0, pc_sel=00, mispredict=0. A following br_op=111 → taken=0.
- br_op=011 taken three times at br_pc=0x8 → counter saturates at 11. Then four not-taken → counter saturates at 00.
- br_op=010 at br_pc=0x8 → pc_sel=10, taken=1, mispredict=0, counter unchanged.
- stall held 3 cycles with br_valid=1 → outputs and table frozen. Assert reset during the stall → all outputs 0 next cycle, counters 01.

Source files
------------

// File: rtl/branch_select_unit_if.sv
// Execute-stage branch bus: flag capture, branch resolution request/result and
// the fetch-side prediction lookup, bundled between the pipeline and the unit.
interface branch_select_unit_if #(
  parameter int PC_W = 32
);
  logic            stall;
  logic            flag_we;
  logic            carry_in;
  logic            zero_in;
  logic            sign_in;
  logic            ovf_in;
  logic            br_valid;
  logic [2:0]      br_op;
  logic [PC_W-1:0] br_pc;
  logic            br_pred;
  logic [PC_W-1:0] lk_pc;
  logic            lk_taken;
  logic            res_valid;
  logic [1:0]      pc_sel;
  logic            taken;
  logic            mispredict;

  modport master (
    output stall, flag_we, carry_in, zero_in, sign_in, ovf_in,
    output br_valid, br_op, br_pc, br_pred, lk_pc,
    input  lk_taken, res_valid, pc_sel, taken, mispredict
  );

  modport slave (
    input  stall, flag_we, carry_in, zero_in, sign_in, ovf_in,
    input  br_valid, br_op, br_pc, br_pred, lk_pc,
    output lk_taken, res_valid, pc_sel, taken, mispredict
  );
endinterface

// File: rtl/branch_select_unit.sv
// Registered branch resolver: latches ALU flags, resolves 8 branch ops into a
// next-PC select plus mispredict, and trains a table of 2-bit counters.
module branch_select_unit #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 16
) (
  input logic            clk,
  input logic            reset,
  branch_select_unit_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [2:0] OP_SEQ  = 3'b000;
  localparam logic [2:0] OP_JIMM = 3'b001;
  localparam logic [2:0] OP_JREG = 3'b010;
  localparam logic [2:0] OP_BC   = 3'b011;
  localparam logic [2:0] OP_BZ   = 3'b100;
  localparam logic [2:0] OP_BS   = 3'b101;
  localparam logic [2:0] OP_BV   = 3'b110;
  localparam logic [2:0] OP_BNZ  = 3'b111;

  localparam logic [1:0] SEL_PC4 = 2'b00;
  localparam logic [1:0] SEL_IMM = 2'b01;
  localparam logic [1:0] SEL_REG = 2'b10;

  localparam logic [1:0] CNT_INIT = 2'b01;

  // Flags packed as {C,Z,S,V}
  logic [3:0] flags_reg;
  logic [3:0] flags_next;

  logic       res_valid_reg, res_valid_next;
  logic [1:0] pc_sel_reg, pc_sel_next;
  logic       taken_reg, taken_next;
  logic       mispredict_reg, mispredict_next;

  logic       eval_taken;
  logic [1:0] eval_sel;
  logic       is_cond;
  logic       update_en;

  logic [IDX_W-1:0] br_idx;
  logic [IDX_W-1:0] lk_idx;

  logic [1:0] counter_reg  [DEPTH];
  logic [1:0] counter_next [DEPTH];

  logic unused_pc_bits;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic up);
    logic [1:0] res;
    res = cnt;
    if (up) begin
      if (cnt != 2'b11) res = cnt + 2'd1;
    end else begin
      if (cnt != 2'b00) res = cnt - 2'd1;
    end
    return res;
  endfunction

  assign br_idx = bus.br_pc[IDX_W+1:2];
  assign lk_idx = bus.lk_pc[IDX_W+1:2];

  // Bits outside the index window alias by design
  assign unused_pc_bits = ^{bus.br_pc[PC_W-1:IDX_W+2], bus.br_pc[1:0],
                            bus.lk_pc[PC_W-1:IDX_W+2], bus.lk_pc[1:0]};

  always_comb begin
    eval_taken = 1'b0;
    eval_sel   = SEL_PC4;
    is_cond    = 1'b1;
    case (bus.br_op)
      OP_SEQ: begin
        is_cond    = 1'b0;
        eval_taken = 1'b0;
      end
      OP_JIMM: begin
        is_cond    = 1'b0;
        eval_taken = 1'b1;
      end
      OP_JREG: begin
        is_cond    = 1'b0;
        eval_taken = 1'b1;
      end
      OP_BC:   eval_taken = flags_reg[3];
      OP_BZ:   eval_taken = flags_reg[2];
      OP_BS:   eval_taken = flags_reg[1];
      OP_BV:   eval_taken = flags_reg[0];
      OP_BNZ:  eval_taken = ~flags_reg[2];
      default: eval_taken = 1'b0;
    endcase

    if (bus.br_op == OP_JREG) begin
      eval_sel = SEL_REG;
    end else if (eval_taken) begin
      eval_sel = SEL_IMM;
    end else begin
      eval_sel = SEL_PC4;
    end
  end

  always_comb begin
    flags_next      = flags_reg;
    res_valid_next  = 1'b0;
    pc_sel_next     = SEL_PC4;
    taken_next      = 1'b0;
    mispredict_next = 1'b0;
    if (bus.flag_we) begin
      flags_next = {bus.carry_in, bus.zero_in, bus.sign_in, bus.ovf_in};
    end
    if (bus.br_valid) begin
      res_valid_next  = 1'b1;
      pc_sel_next     = eval_sel;
      taken_next      = eval_taken;
      mispredict_next = is_cond & (eval_taken != bus.br_pred);
    end
  end

  assign update_en = bus.br_valid & is_cond;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_counter
      assign counter_next[gi] = (update_en && (br_idx == IDX_W'(gi)))
                                ? sat_update(counter_reg[gi], eval_taken)
                                : counter_reg[gi];
    end
  endgenerate

  // Reset wins over stall; stall freezes every piece of state
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_reg      <= 4'b0000;
      res_valid_reg  <= 1'b0;
      pc_sel_reg     <= SEL_PC4;
      taken_reg      <= 1'b0;
      mispredict_reg <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        counter_reg[i] <= CNT_INIT;
      end
    end else if (!bus.stall) begin
      flags_reg      <= flags_next;
      res_valid_reg  <= res_valid_next;
      pc_sel_reg     <= pc_sel_next;
      taken_reg      <= taken_next;
      mispredict_reg <= mispredict_next;
      for (int i = 0; i < DEPTH; i++) begin
        counter_reg[i] <= counter_next[i];
      end
    end
  end

  // Lookup reads current state, so a same-cycle update is not visible yet
  assign bus.lk_taken   = counter_reg[lk_idx][1];
  assign bus.res_valid  = res_valid_reg;
  assign bus.pc_sel     = pc_sel_reg;
  assign bus.taken      = taken_reg;
  assign bus.mispredict = mispredict_reg;
endmodule

// File: tb/tb_branch_select_unit.sv
// Directed bench for branch_select_unit: flags, branch ops, counter training,
// stall freeze and reset-under-stall.
module tb_branch_select_unit;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  branch_select_unit_if #(.PC_W(32)) bus ();

  branch_select_unit #(.PC_W(32), .DEPTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall    = 1'b0;
    bus.flag_we  = 1'b0;
    bus.carry_in = 1'b0;
    bus.zero_in  = 1'b0;
    bus.sign_in  = 1'b0;
    bus.ovf_in   = 1'b0;
    bus.br_valid = 1'b0;
    bus.br_op    = 3'b000;
    bus.br_pc    = 32'h0;
    bus.br_pred  = 1'b0;
    bus.lk_pc    = 32'h0;
  endtask

  task automatic set_flags(input logic c, input logic z, input logic s, input logic v);
    bus.flag_we  = 1'b1;
    bus.carry_in = c;
    bus.zero_in  = z;
    bus.sign_in  = s;
    bus.ovf_in   = v;
    step();
    bus.flag_we  = 1'b0;
  endtask

  task automatic branch(input logic [2:0] op, input logic [31:0] pc, input logic pred);
    bus.br_valid = 1'b1;
    bus.br_op    = op;
    bus.br_pc    = pc;
    bus.br_pred  = pred;
    step();
    bus.br_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
    n_checks++;
    if ({bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict} !== 5'b0) begin
      n_fails++;
      $display("FAIL reset_outputs: got %b want 00000",
               {bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict});
    end
    for (int i = 0; i < 16; i++) begin
      bus.lk_pc = 32'(i * 4);
      #1;
      n_checks++;
      if (bus.lk_taken !== 1'b0) begin
        n_fails++;
        $display("FAIL reset_lk_taken[%0d]: got %b want 0", i, bus.lk_taken);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_carry_taken();
    set_flags(1'b1, 1'b0, 1'b0, 1'b0);
    branch(3'b011, 32'h40, 1'b0);
    n_checks++;
    if ({bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict} !== 5'b1_01_1_1) begin
      n_fails++;
      $display("FAIL carry_taken: got %b want 10111",
               {bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict});
    end
    bus.lk_pc = 32'h40;
    #1;
    n_checks++;
    if (bus.lk_taken !== 1'b1) begin
      n_fails++;
      $display("FAIL carry_lk_0x40: got %b want 1", bus.lk_taken);
    end
    step();
    n_checks++;
    if ({bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict} !== 5'b0) begin
      n_fails++;
      $display("FAIL idle_clears: got %b want 00000",
               {bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict});
    end
    $display("test_carry_taken done");
  endtask

  task automatic test_flag_timing();
    // Flag write and branch in the same cycle: branch sees old Z=0
    bus.flag_we  = 1'b1;
    bus.carry_in = 1'b1;
    bus.zero_in  = 1'b1;
    bus.sign_in  = 1'b0;
    bus.ovf_in   = 1'b0;
    branch(3'b100, 32'h10, 1'b0);
    bus.flag_we  = 1'b0;
    n_checks++;
    if ({bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict} !== 5'b1_00_0_0) begin
      n_fails++;
      $display("FAIL same_cycle_bz: got %b want 10000",
               {bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict});
    end
    branch(3'b111, 32'h10, 1'b1);
    n_checks++;
    if ({bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict} !== 5'b1_00_0_1) begin
      n_fails++;
      $display("FAIL bnz_after_z: got %b want 10001",
               {bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict});
    end
    set_flags(1'b0, 1'b0, 1'b1, 1'b0);
    branch(3'b101, 32'h20, 1'b1);
    n_checks++;
    if ({bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict} !== 5'b1_01_1_0) begin
      n_fails++;
      $display("FAIL bs_taken: got %b want 10110",
               {bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict});
    end
    branch(3'b110, 32'h20, 1'b1);
    n_checks++;
    if ({bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict} !== 5'b1_00_0_1) begin
      n_fails++;
      $display("FAIL bv_not_taken: got %b want 10001",
               {bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict});
    end
    branch(3'b111, 32'h20, 1'b0);
    n_checks++;
    if ({bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict} !== 5'b1_01_1_1) begin
      n_fails++;
      $display("FAIL bnz_taken: got %b want 10111",
               {bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict});
    end
    $display("test_flag_timing done");
  endtask

  task automatic test_saturation();
    logic exp_up [3];
    logic exp_dn [4];
    exp_up = '{1'b1, 1'b1, 1'b1};
    exp_dn = '{1'b1, 1'b0, 1'b0, 1'b0};
    bus.lk_pc = 32'h8;
    set_flags(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      branch(3'b011, 32'h8, 1'b1);
      n_checks++;
      if (bus.lk_taken !== exp_up[i] || bus.mispredict !== 1'b0) begin
        n_fails++;
        $display("FAIL sat_up[%0d]: lk_taken=%b mispredict=%b want %b 0",
                 i, bus.lk_taken, bus.mispredict, exp_up[i]);
      end
    end
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    // 11 -> 10 -> 01 -> 00 -> 00
    for (int i = 0; i < 4; i++) begin
      branch(3'b011, 32'h8, 1'b1);
      n_checks++;
      if (bus.lk_taken !== exp_dn[i] || bus.mispredict !== 1'b1) begin
        n_fails++;
        $display("FAIL sat_down[%0d]: lk_taken=%b mispredict=%b want %b 1",
                 i, bus.lk_taken, bus.mispredict, exp_dn[i]);
      end
    end
    set_flags(1'b1, 1'b0, 1'b0, 1'b0);
    branch(3'b011, 32'h8, 1'b0);
    n_checks++;
    if (bus.lk_taken !== 1'b0) begin
      n_fails++;
      $display("FAIL sat_floor: lk_taken got %b want 0", bus.lk_taken);
    end
    $display("test_saturation done");
  endtask

  task automatic test_back_to_back();
    // Counter at 0x8 is 01 here; unconditional ops must leave it there
    bus.lk_pc = 32'h8;
    branch(3'b010, 32'h8, 1'b1);
    n_checks++;
    if ({bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict} !== 5'b1_10_1_0) begin
      n_fails++;
      $display("FAIL jump_reg: got %b want 11010",
               {bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict});
    end
    branch(3'b001, 32'h8, 1'b0);
    n_checks++;
    if ({bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict} !== 5'b1_01_1_0) begin
      n_fails++;
      $display("FAIL jump_imm: got %b want 10110",
               {bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict});
    end
    branch(3'b000, 32'h8, 1'b1);
    n_checks++;
    if ({bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict} !== 5'b1_00_0_0) begin
      n_fails++;
      $display("FAIL seq: got %b want 10000",
               {bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict});
    end
    n_checks++;
    if (bus.lk_taken !== 1'b0) begin
      n_fails++;
      $display("FAIL uncond_no_update: lk_taken got %b want 0", bus.lk_taken);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_stall_reset();
    // C=1 at entry; counter 0x8 = 01, counter 0x40 = 10
    bus.lk_pc = 32'h8;
    branch(3'b001, 32'h100, 1'b0);
    bus.stall    = 1'b1;
    bus.br_valid = 1'b1;
    bus.br_op    = 3'b011;
    bus.br_pc    = 32'h8;
    bus.br_pred  = 1'b0;
    bus.flag_we  = 1'b1;
    bus.carry_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict} !== 5'b1_01_1_0 ||
          bus.lk_taken !== 1'b0) begin
        n_fails++;
        $display("FAIL stall_hold[%0d]: got %b lk=%b want 10110 lk=0", i,
                 {bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict}, bus.lk_taken);
      end
    end
    bus.stall   = 1'b0;
    bus.flag_we = 1'b0;
    step();
    n_checks++;
    if ({bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict} !== 5'b1_01_1_1 ||
        bus.lk_taken !== 1'b1) begin
      n_fails++;
      $display("FAIL after_stall: got %b lk=%b want 10111 lk=1",
               {bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict}, bus.lk_taken);
    end
    bus.stall = 1'b1;
    reset     = 1'b1;
    step();
    reset     = 1'b0;
    bus.stall = 1'b0;
    bus.br_valid = 1'b0;
    n_checks++;
    if ({bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict} !== 5'b0 ||
        bus.lk_taken !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_in_stall: got %b lk=%b want 00000 lk=0",
               {bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict}, bus.lk_taken);
    end
    bus.lk_pc = 32'h40;
    #1;
    n_checks++;
    if (bus.lk_taken !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_counter_0x40: lk_taken got %b want 0", bus.lk_taken);
    end
    branch(3'b011, 32'h40, 1'b1);
    n_checks++;
    if ({bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict} !== 5'b1_00_0_1) begin
      n_fails++;
      $display("FAIL flags_cleared: got %b want 10001",
               {bus.res_valid, bus.pc_sel, bus.taken, bus.mispredict});
    end
    set_flags(1'b1, 1'b0, 1'b0, 1'b0);
    branch(3'b011, 32'h40, 1'b1);
    // 01 -> 00 -> 01: MSB stays 0
    n_checks++;
    if (bus.lk_taken !== 1'b0) begin
      n_fails++;
      $display("FAIL post_reset_train: lk_taken got %b want 0", bus.lk_taken);
    end
    branch(3'b011, 32'h40, 1'b1);
    n_checks++;
    if (bus.lk_taken !== 1'b1) begin
      n_fails++;
      $display("FAIL post_reset_train2: lk_taken got %b want 1", bus.lk_taken);
    end
    $display("test_stall_reset done");
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_carry_taken();
    test_flag_timing();
    test_saturation();
    test_back_to_back();
    test_stall_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
